// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between a test controller (master) and the truth-table sweeper (slave).
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                  start;
  logic [2**N_IN-1:0]    expected;
  logic                  busy;
  logic                  done;
  logic [2**N_IN-1:0]    table_out;
  logic [N_IN:0]         mismatch_cnt;
  logic [N_IN-1:0]       first_fail;
  logic                  fail_valid;
  logic                  pass;

  modport master (
    output start, expected,
    input  busy, done, table_out, mismatch_cnt, first_fail, fail_valid, pass
  );

  modport slave (
    input  start, expected,
    output busy, done, table_out, mismatch_cnt, first_fail, fail_valid, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a combinational block, holds each for SETTLE cycles,
// samples the block output and compares it with a golden truth table latched at start.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave ctl,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in
);
  localparam int NV = 2**N_IN;
  localparam int WW = $clog2(SETTLE+1);
  localparam logic [WW-1:0]   WLAST = WW'(SETTLE-1);
  localparam logic [N_IN-1:0] VLAST = N_IN'(NV-1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t          state, state_next;
  logic [WW-1:0]   wcnt;
  logic [NV-1:0]   exp_q;
  logic [NV-1:0]   table_q;
  logic [N_IN:0]   cnt_q;
  logic [N_IN-1:0] first_q;
  logic            fail_valid_q;
  logic            pass_q;
  logic            busy_q;
  logic            done_q;
  logic            sample;
  logic            miss;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: if (ctl.start) state_next = HOLD;
      HOLD: begin
        if (wcnt == WLAST) begin
          sample = 1'b1;
          if (vec == VLAST) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign miss = sample && (f_in != exp_q[vec]);

  // Results are registered so that pass is already valid in the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec          <= '0;
      wcnt         <= '0;
      exp_q        <= '0;
      table_q      <= '0;
      cnt_q        <= '0;
      first_q      <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl.start) begin
            exp_q        <= ctl.expected;
            vec          <= '0;
            wcnt         <= '0;
            table_q      <= '0;
            cnt_q        <= '0;
            first_q      <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        HOLD: begin
          if (sample) begin
            table_q[vec] <= f_in;
            if (miss) cnt_q <= cnt_q + 1'b1;
            if (miss && !fail_valid_q) begin
              first_q      <= vec;
              fail_valid_q <= 1'b1;
            end
            // The last vector stays on vec after the sweep rather than wrapping.
            if (vec == VLAST) begin
              done_q <= 1'b1;
              pass_q <= (cnt_q == '0) && !miss;
            end else begin
              vec  <= vec + 1'b1;
              wcnt <= '0;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ctl.busy         = busy_q;
  assign ctl.done         = done_q;
  assign ctl.table_out    = table_q;
  assign ctl.mismatch_cnt = cnt_q;
  assign ctl.first_fail   = first_q;
  assign ctl.fail_valid   = fail_valid_q;
  assign ctl.pass         = pass_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with SETTLE=1 and one with SETTLE=3, each
// sweeping a modelled combinational block; results compared with a truth-table reference.
module tb_truth_table_sweeper;
  localparam int NV = 8;

  typedef struct {
    logic       sel;
    logic [7:0] circ;
    logic [7:0] expv;
    logic       disturb;
    logic [7:0] want_table;
    logic [3:0] want_cnt;
    logic [2:0] want_first;
    logic       want_fv;
    logic       want_pass;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] vec1, vec3;
  logic [7:0] circ1, circ3;
  logic       f1, f3;
  logic       sel;

  truth_table_sweeper_if #(.N_IN(3)) bus1 ();
  truth_table_sweeper_if #(.N_IN(3)) bus3 ();

  assign f1 = circ1[vec1];
  assign f3 = circ3[vec3];

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctl(bus1), .vec(vec1), .f_in(f1)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ctl(bus3), .vec(vec3), .f_in(f3)
  );

  logic [2:0] cur_vec;
  logic       cur_busy, cur_done, cur_fv, cur_pass;
  logic [7:0] cur_table;
  logic [3:0] cur_cnt;
  logic [2:0] cur_first;

  always_comb begin
    if (sel) begin
      cur_vec = vec3; cur_busy = bus3.busy; cur_done = bus3.done; cur_table = bus3.table_out;
      cur_cnt = bus3.mismatch_cnt; cur_first = bus3.first_fail; cur_fv = bus3.fail_valid;
      cur_pass = bus3.pass;
    end else begin
      cur_vec = vec1; cur_busy = bus1.busy; cur_done = bus1.done; cur_table = bus1.table_out;
      cur_cnt = bus1.mismatch_cnt; cur_first = bus1.first_fail; cur_fv = bus1.fail_valid;
      cur_pass = bus1.pass;
    end
  end

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act === want) nPass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  task automatic setStart(input logic v);
    if (sel) bus3.start = v; else bus1.start = v;
  endtask

  task automatic setExp(input logic [7:0] v);
    if (sel) bus3.expected = v; else bus1.expected = v;
  endtask

  task automatic setCirc(input logic [7:0] v);
    if (sel) circ3 = v; else circ1 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden block f = A&B | C, with vector bit 2 = A and bit 0 = C.
  function automatic logic [7:0] goldenCirc();
    logic [7:0] t;
    for (int i = 0; i < NV; i++) t[i] = ((i / 4) % 2 == 1 && (i / 2) % 2 == 1) || (i % 2 == 1);
    return t;
  endfunction

  // Reference: what a sweep of block table c against golden table e must report.
  function automatic vec_t modelSweep(input logic s, input logic [7:0] c, input logic [7:0] e);
    vec_t r;
    r.sel = s; r.circ = c; r.expv = e; r.disturb = 1'b0;
    r.want_table = c;
    r.want_cnt = 0;
    r.want_first = 0;
    r.want_fv = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (c[i] != e[i]) begin
        if (!r.want_fv) r.want_first = 3'(i);
        r.want_fv = 1'b1;
        r.want_cnt = r.want_cnt + 4'd1;
      end
    end
    r.want_pass = (r.want_cnt == 0);
    return r;
  endfunction

  task automatic checkResults(input string tag, input vec_t v);
    checkOutput({tag, "_table"}, 32'(cur_table), 32'(v.want_table));
    checkOutput({tag, "_cnt"},   32'(cur_cnt),   32'(v.want_cnt));
    checkOutput({tag, "_fv"},    32'(cur_fv),    32'(v.want_fv));
    if (v.want_fv) checkOutput({tag, "_first"}, 32'(cur_first), 32'(v.want_first));
    checkOutput({tag, "_pass"},  32'(cur_pass),  32'(v.want_pass));
  endtask

  // Runs one full sweep: start pulse, per-edge vec tracking, done latency and results.
  task automatic applyStimulus(input string tag, input vec_t v);
    int settle, n;
    logic seen, vecOk;
    sel = v.sel;
    settle = v.sel ? 3 : 1;
    setCirc(v.circ);
    setExp(v.expv);
    setStart(1'b1);
    tick();
    setStart(1'b0);
    checkOutput({tag, "_busy_start"}, 32'(cur_busy), 32'd1);
    n = 0; seen = 1'b0; vecOk = 1'b1;
    while (!seen && n < 200) begin
      if (n < NV * settle && cur_vec !== 3'(n / settle)) vecOk = 1'b0;
      if (v.disturb) begin
        setStart(cur_vec == 3'd3);
        if (cur_vec == 3'd5) setExp(8'h00);
      end
      tick();
      n++;
      if (cur_done === 1'b1) seen = 1'b1;
    end
    setStart(1'b0);
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(n), 32'(NV * settle));
    checkOutput({tag, "_vec_steps"}, 32'(vecOk), 32'd1);
    checkOutput({tag, "_vec_last"}, 32'(cur_vec), 32'd7);
    checkResults(tag, v);
    tick();
    checkOutput({tag, "_done_pulse"}, 32'({cur_done, cur_busy}), 32'd0);
    checkResults({tag, "_held"}, v);
  endtask

  vec_t tbl[5];

  initial begin
    vec_t r;
    int n;
    logic seen;
    sel = 1'b0;
    bus1.start = 1'b0; bus3.start = 1'b0;
    bus1.expected = '0; bus3.expected = '0;
    circ1 = '0; circ3 = '0;

    tbl[0] = '{1'b0, goldenCirc(), 8'hEA, 1'b0, 8'hEA, 4'd0, 3'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'hC0,        8'hEA, 1'b0, 8'hC0, 4'd3, 3'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, goldenCirc(), 8'hEA, 1'b1, 8'hEA, 4'd0, 3'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, goldenCirc(), 8'hEA, 1'b0, 8'hEA, 4'd0, 3'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'hC0,        8'hEA, 1'b0, 8'hC0, 4'd3, 3'd1, 1'b1, 1'b0};

    rst_n = 1'b0;
    tick(); tick();
    checkOutput("rst_busy_done", 32'({bus1.busy, bus1.done, bus3.busy, bus3.done}), 32'd0);
    checkOutput("rst_vec", 32'({vec1, vec3}), 32'd0);
    checkOutput("rst_results", 32'({bus1.table_out, bus1.mismatch_cnt, bus1.first_fail,
                                   bus1.fail_valid, bus1.pass}), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    checkOutput("idle_after_rst", 32'({bus1.busy, bus1.done, vec1, bus1.mismatch_cnt, bus1.pass}), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] c, e;
      c = 8'($urandom);
      e = ($urandom_range(0, 2) == 0) ? c : 8'($urandom);
      r = modelSweep(1'($urandom_range(0, 1)), c, e);
      applyStimulus($sformatf("rnd%0d", i), r);
    end

    // Reset mid-sweep at vector 4 must abort silently.
    sel = 1'b0;
    setCirc(goldenCirc());
    setExp(8'hEA);
    setStart(1'b1);
    tick();
    setStart(1'b0);
    n = 0;
    while (vec1 !== 3'd4 && n < 20) begin tick(); n++; end
    checkOutput("abort_reach_vec4", 32'(vec1), 32'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_cleared", 32'({bus1.busy, bus1.done, vec1, bus1.table_out, bus1.mismatch_cnt,
                                     bus1.fail_valid, bus1.pass}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus1.done === 1'b1) seen = 1'b1; end
    checkOutput("abort_no_done", 32'(seen), 32'd0);
    applyStimulus("after_abort", tbl[0]);

    // start held high: a fresh sweep is accepted in the IDLE cycle after DONE.
    sel = 1'b0;
    setCirc(goldenCirc());
    setExp(8'hEA);
    setStart(1'b1);
    n = 0;
    while (bus1.done !== 1'b1 && n < 30) begin tick(); n++; end
    checkOutput("held_first_done", 32'(bus1.done), 32'd1);
    tick();
    checkOutput("held_idle_gap", 32'({bus1.busy, bus1.done}), 32'd0);
    tick();
    checkOutput("held_restart", 32'({bus1.busy, vec1, bus1.pass}), 32'({1'b1, 3'd0, 1'b0}));
    setStart(1'b0);
    n = 0;
    while (bus1.busy === 1'b1 && n < 30) begin tick(); n++; end
    checkOutput("held_second_pass", 32'({bus1.busy, bus1.pass, bus1.table_out}), 32'({1'b0, 1'b1, 8'hEA}));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
